// File: rtl/pic_fetch_sequencer.sv
// Instruction fetch and sequencing unit for a PIC16F84-class core.
// Generates the Q1..Q4 phase counter, the program counter / program memory
// address, the instruction register feeding the ALU and the hardware return
// stack. All PC, OP_CODE and stack updates take effect on the Q4 edge.
module pic_fetch_sequencer #(
    parameter int                  PC_WIDTH     = 13,
    parameter int                  STACK_DEPTH  = 8,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 13'h0000,
    parameter logic [PC_WIDTH-1:0] INT_VECTOR   = 13'h0004
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [13:0]         PROG_DATA,
    input  logic [4:0]          PCLATH,
    input  logic                SKIP,
    input  logic                INT_REQ,
    input  logic                GIE,
    output logic [PC_WIDTH-1:0] PROG_ADDR,
    output logic [13:0]         OP_CODE,
    output logic [1:0]          Q_PHASE,
    output logic                INSTR_EN,
    output logic                GIE_SET,
    output logic                GIE_CLR,
    output logic                STACK_OVF
);

    localparam int SP_W = $clog2(STACK_DEPTH);

    // Q-phase encoding: only Q1 (reset value) and Q4 (commit edge) matter here.
    localparam logic [1:0] Q1 = 2'd0;
    localparam logic [1:0] Q4 = 2'd3;

    localparam logic [13:0]         NOP      = 14'h0000;
    localparam logic [13:0]         OP_RET   = 14'h0008;
    localparam logic [13:0]         OP_RETFI = 14'h0009;
    localparam logic [PC_WIDTH-1:0] PC_ONE   = PC_WIDTH'(1);
    localparam logic [SP_W-1:0]     SP_ONE   = SP_W'(1);
    localparam logic [SP_W:0]       CNT_ONE  = (SP_W + 1)'(1);
    localparam logic [SP_W:0]       CNT_FULL = (SP_W + 1)'(STACK_DEPTH);

    // Registered state
    logic [1:0]          q_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [13:0]         op_q;
    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [SP_W-1:0]     sp_q;      // next free slot (push writes here)
    logic [SP_W:0]       cnt_q;     // live entries, saturates at STACK_DEPTH
    logic                ovf_q;
    logic                set_q;
    logic                clr_q;

    // Next-state and decode
    logic [PC_WIDTH-1:0] pc_d;
    logic [13:0]         op_d;
    logic                set_d;
    logic                clr_d;
    logic                push;
    logic                pop;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] jump_target;
    logic [PC_WIDTH-1:0] stack_top;
    logic [SP_W-1:0]     sp_dec;
    logic                is_goto;
    logic                is_call;
    logic                is_ret;
    logic                is_retfie;
    logic                is_skip;

    // PCLATH[2:0] belongs to computed-goto writes of PCL, not to GOTO/CALL.
    logic                unused_pclath;
    assign unused_pclath = ^PCLATH[2:0];

    assign pc_inc      = pc_q + PC_ONE;
    assign jump_target = PC_WIDTH'({PCLATH[4:3], op_q[10:0]});
    assign sp_dec      = sp_q - SP_ONE;
    assign stack_top   = stack_q[sp_dec];

    // Classify the instruction currently held in the instruction register.
    always_comb begin
        is_goto   = (op_q[13:11] == 3'b101);
        is_call   = (op_q[13:11] == 3'b100);
        is_retfie = (op_q == OP_RETFI);
        is_ret    = (op_q == OP_RET) || is_retfie || (op_q[13:10] == 4'b1101);
        // DECFSZ, INCFSZ, BTFSC, BTFSS
        is_skip   = (op_q[13:8] == 6'b001011) || (op_q[13:8] == 6'b001111) ||
                    (op_q[13:11] == 3'b011);
    end

    // Q4 sequencing decision: branch, return, skip, interrupt entry or fetch.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves a signal unassigned and no latch is inferred.
        pc_d  = pc_q;
        op_d  = op_q;
        set_d = 1'b0;
        clr_d = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        if (q_q == Q4) begin
            if (is_goto) begin
                pc_d = jump_target;
                op_d = NOP;
            end else if (is_call) begin
                push = 1'b1;
                pc_d = jump_target;
                op_d = NOP;
            end else if (is_ret) begin
                pop   = 1'b1;
                pc_d  = stack_top;
                op_d  = NOP;
                set_d = is_retfie;
            end else if (is_skip && SKIP) begin
                // The prefetched word is dropped; its address is stepped over.
                pc_d = pc_inc;
                op_d = NOP;
            end else if (INT_REQ && GIE) begin
                // The prefetched word is dropped; it is re-fetched on return.
                push  = 1'b1;
                pc_d  = INT_VECTOR;
                op_d  = NOP;
                clr_d = 1'b1;
            end else begin
                pc_d = pc_inc;
                op_d = PROG_DATA;
            end
        end
    end

    // Phase counter, PC, instruction register and GIE pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= Q1;
            pc_q  <= RESET_VECTOR;
            op_q  <= NOP;
            set_q <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples values from before this edge.
            q_q   <= q_q + 2'd1;
            pc_q  <= pc_d;
            op_q  <= op_d;
            set_q <= set_d;
            clr_q <= clr_d;
        end
    end

    // Circular return stack with sticky overflow/underflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the stack entries are reset explicitly because a pop on an
            // empty stack must return a defined (zero) value, so this array is
            // flops rather than an unreset RAM.
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (push) begin
            stack_q[sp_q] <= pc_q;
            sp_q          <= sp_q + SP_ONE;
            if (cnt_q == CNT_FULL) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end else if (pop) begin
            sp_q <= sp_dec;
            if (cnt_q == '0) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

    assign PROG_ADDR = pc_q;
    assign OP_CODE   = op_q;
    assign Q_PHASE   = q_q;
    assign INSTR_EN  = (q_q == Q4);
    assign GIE_SET   = set_q;
    assign GIE_CLR   = clr_q;
    assign STACK_OVF = ovf_q;

endmodule
